// File: rtl/pll_sup_pkg.sv
// Shared types and helpers for the PLL lock supervisor: FSM state encoding and
// the width calculation for the shared state counter.
package pll_sup_pkg;

  typedef enum logic [1:0] {
    RESET_PLL = 2'd0,
    WAIT_LOCK = 2'd1,
    STABLE    = 2'd2,
    RUN       = 2'd3
  } state_e;

  // One counter serves all three timed phases, so it must hold the largest terminal count.
  function automatic int cnt_width(input int rst_cyc, input int tmo_cyc, input int stb_cyc);
    int m;
    m = rst_cyc;
    if (tmo_cyc > m) m = tmo_cyc;
    if (stb_cyc > m) m = stb_cyc;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/bit_sync.sv
// Multi-flop synchronizer for a single asynchronous level entering the clk domain.
// Flops reset to 0; no other logic in the chain.
module bit_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) chain <= '0;
    else     chain <= {chain[STAGES-2:0], d};
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/pll_lock_supervisor.sv
// PLL reset/lock supervisor: pulses pll_rst, waits for a synchronized lock, retries on
// timeout and raises a registered ready after stable lock. Status counters: PLL_SUP_STATUS_EN.
module pll_lock_supervisor
  import pll_sup_pkg::*;
#(
  parameter int RST_PULSE_CYC    = 16,
  parameter int LOCK_TIMEOUT_CYC = 500000,
  parameter int LOCK_STABLE_CYC  = 1024,
  parameter int SYNC_STAGES      = 2,
  parameter int CNT_W            = 8
) (
  input  logic             refclk,
  input  logic             rst,
  input  logic             pll_locked,
  input  logic             force_relock,
  output logic             pll_rst,
  output logic             ready
`ifdef PLL_SUP_STATUS_EN
  ,
  output logic [CNT_W-1:0] loss_cnt,
  output logic [CNT_W-1:0] tmo_cnt
`endif
);

  localparam int CW = cnt_width(RST_PULSE_CYC, LOCK_TIMEOUT_CYC, LOCK_STABLE_CYC);
  localparam logic [CW-1:0] RST_LAST = CW'(RST_PULSE_CYC - 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(LOCK_TIMEOUT_CYC - 1);
  localparam logic [CW-1:0] STB_LAST = CW'(LOCK_STABLE_CYC - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          locked_s;
`ifdef PLL_SUP_STATUS_EN
  logic          loss_inc, tmo_inc;
`endif

  bit_sync #(.STAGES(SYNC_STAGES)) u_lock_sync (
    .clk (refclk),
    .rst (rst),
    .d   (pll_locked),
    .q   (locked_s)
  );

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
`ifdef PLL_SUP_STATUS_EN
    loss_inc = 1'b0;
    tmo_inc  = 1'b0;
`endif
    if (force_relock) begin
      state_d = RESET_PLL;
    end else begin
      unique case (state_q)
        RESET_PLL: if (cnt_q == RST_LAST) state_d = WAIT_LOCK;
        WAIT_LOCK: begin
          if (locked_s) state_d = STABLE;
          else if (cnt_q == TMO_LAST) begin
            state_d = RESET_PLL;
`ifdef PLL_SUP_STATUS_EN
            tmo_inc = 1'b1;
`endif
          end
        end
        STABLE: begin
          if (!locked_s) state_d = WAIT_LOCK;
          else if (cnt_q == STB_LAST) state_d = RUN;
        end
        RUN: begin
          cnt_d = cnt_q;  // no timing in RUN; hold rather than toggle
          if (!locked_s) begin
            state_d = RESET_PLL;
`ifdef PLL_SUP_STATUS_EN
            loss_inc = 1'b1;
`endif
          end
        end
        default: state_d = RESET_PLL;
      endcase
    end
    // A relock request while already in RESET_PLL also restarts the pulse.
    if (force_relock || (state_d != state_q)) cnt_d = '0;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state_q <= RESET_PLL;
      cnt_q   <= '0;
      pll_rst <= 1'b1;
      ready   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pll_rst <= (state_d == RESET_PLL);
      ready   <= (state_d == RUN);
    end
  end

`ifdef PLL_SUP_STATUS_EN
  localparam logic [CNT_W-1:0] SAT = '1;

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      loss_cnt <= '0;
      tmo_cnt  <= '0;
    end else begin
      if (loss_inc && (loss_cnt != SAT)) loss_cnt <= loss_cnt + CNT_W'(1);
      if (tmo_inc && (tmo_cnt != SAT))   tmo_cnt  <= tmo_cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Scoreboard bench for pll_lock_supervisor: a timer-based reference model queues the
// expected outputs per edge; a monitor pops and compares on the opposite edge.
module tb_pll_lock_supervisor;

  localparam int RST_PULSE_CYC    = 4;
  localparam int LOCK_TIMEOUT_CYC = 20;
  localparam int LOCK_STABLE_CYC  = 8;
  localparam int SYNC_STAGES      = 2;
  localparam int CNT_W            = 8;
  localparam int SAT              = (1 << CNT_W) - 1;

  logic refclk = 1'b0;
  logic rst = 1'b1;
  logic pll_locked = 1'b0;
  logic force_relock = 1'b0;
  logic pll_rst, ready;
`ifdef PLL_SUP_STATUS_EN
  logic [CNT_W-1:0] loss_cnt, tmo_cnt;
`endif

  int errors = 0;
  int checks = 0;

  always #5 refclk = ~refclk;

  pll_lock_supervisor #(
    .RST_PULSE_CYC    (RST_PULSE_CYC),
    .LOCK_TIMEOUT_CYC (LOCK_TIMEOUT_CYC),
    .LOCK_STABLE_CYC  (LOCK_STABLE_CYC),
    .SYNC_STAGES      (SYNC_STAGES),
    .CNT_W            (CNT_W)
  ) dut (
    .refclk       (refclk),
    .rst          (rst),
    .pll_locked   (pll_locked),
    .force_relock (force_relock),
    .pll_rst      (pll_rst),
    .ready        (ready)
`ifdef PLL_SUP_STATUS_EN
    ,
    .loss_cnt     (loss_cnt),
    .tmo_cnt      (tmo_cnt)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic pll_rst;
    logic ready;
    int   loss;
    int   tmo;
  } exp_t;

  typedef enum {M_PULSE, M_WAIT, M_SETTLE, M_RUN} phase_e;

  exp_t   exp_q[$];
  phase_e m_phase = M_PULSE;
  int     m_left  = RST_PULSE_CYC;   // cycles remaining in the current timed phase
  int     m_loss  = 0;
  int     m_tmo   = 0;
  bit [SYNC_STAGES-1:0] m_hist = '0;

  initial forever begin
    bit ls;
    @(posedge refclk);
    if (rst) begin
      m_phase = M_PULSE; m_left = RST_PULSE_CYC;
      m_loss = 0; m_tmo = 0; m_hist = '0;
    end else begin
      ls     = m_hist[SYNC_STAGES-1];
      m_hist = {m_hist[SYNC_STAGES-2:0], pll_locked};
      if (force_relock) begin
        m_phase = M_PULSE; m_left = RST_PULSE_CYC;
      end else begin
        case (m_phase)
          M_PULSE: begin
            m_left--;
            if (m_left == 0) begin m_phase = M_WAIT; m_left = LOCK_TIMEOUT_CYC; end
          end
          M_WAIT: begin
            if (ls) begin
              m_phase = M_SETTLE; m_left = LOCK_STABLE_CYC;
            end else begin
              m_left--;
              if (m_left == 0) begin
                m_phase = M_PULSE; m_left = RST_PULSE_CYC;
                if (m_tmo < SAT) m_tmo++;
              end
            end
          end
          M_SETTLE: begin
            if (!ls) begin
              m_phase = M_WAIT; m_left = LOCK_TIMEOUT_CYC;
            end else begin
              m_left--;
              if (m_left == 0) m_phase = M_RUN;
            end
          end
          M_RUN: begin
            if (!ls) begin
              m_phase = M_PULSE; m_left = RST_PULSE_CYC;
              if (m_loss < SAT) m_loss++;
            end
          end
        endcase
      end
    end
    exp_q.push_back('{pll_rst: (m_phase == M_PULSE), ready: (m_phase == M_RUN),
                      loss: m_loss, tmo: m_tmo});
  end

  // ---------------- monitor ----------------
  initial forever begin
    exp_t e;
    @(negedge refclk);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("sb_pll_rst", 32'(pll_rst), 32'(e.pll_rst));
      check("sb_ready", 32'(ready), 32'(e.ready));
`ifdef PLL_SUP_STATUS_EN
      check("sb_loss_cnt", 32'(loss_cnt), 32'(e.loss));
      check("sb_tmo_cnt", 32'(tmo_cnt), 32'(e.tmo));
`endif
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc(input int n);
    repeat (n) @(negedge refclk);
  endtask

  // Raise rst between edges and verify outputs respond with no clock edge.
  task automatic do_reset(input string tag);
    @(negedge refclk);
    #2 rst = 1'b1;
    #1;
    check({tag, "_imm_pll_rst"}, 32'(pll_rst), 32'd1);
    check({tag, "_imm_ready"}, 32'(ready), 32'd0);
`ifdef PLL_SUP_STATUS_EN
    check({tag, "_imm_loss"}, 32'(loss_cnt), 32'd0);
    check({tag, "_imm_tmo"}, 32'(tmo_cnt), 32'd0);
`endif
    cyc(2);
    #2 rst = 1'b0;
  endtask

  // Negedges until the chosen output (0: pll_rst, 1: ready) equals val, capped at bound.
  task automatic cycles_until(input bit sel, input logic val, input int bound, output int n);
    n = 0;
    while ((((sel) ? ready : pll_rst) !== val) && (n < bound)) begin
      @(negedge refclk);
      n++;
    end
  endtask

  localparam int LOCK_LAT = SYNC_STAGES + LOCK_STABLE_CYC + 1;
  localparam int LOSS_LAT = SYNC_STAGES + 1;

  initial begin
    int n;
    cyc(3);
    do_reset("rst_initial");

    // Power-up: pulse width, then lock latency.
    cycles_until(1'b0, 1'b0, 50, n);
    check("pulse_width_initial", 32'(n), 32'(RST_PULSE_CYC));
    cyc(10);
    pll_locked = 1'b1;
    cycles_until(1'b1, 1'b1, 100, n);
    check("lock_to_ready", 32'(n), 32'(LOCK_LAT));

    // One-cycle lock drop in RUN.
    pll_locked = 1'b0;
    @(negedge refclk);
    n = 1;
    pll_locked = 1'b1;
    while (ready === 1'b1 && n < 50) begin @(negedge refclk); n++; end
    check("loss_to_ready_fall", 32'(n), 32'(LOSS_LAT));
    cycles_until(1'b0, 1'b0, 50, n);
    check("pulse_width_after_loss", 32'(n), 32'(RST_PULSE_CYC));
    cycles_until(1'b1, 1'b1, 100, n);
    check("relock_after_loss", 32'(n), 32'(LOCK_STABLE_CYC + 1));

    // Lock drop while settling: the stable count restarts.
    force_relock = 1'b1;
    @(negedge refclk);
    force_relock = 1'b0;
    cycles_until(1'b0, 1'b0, 50, n);
    check("pulse_width_forced", 32'(n), 32'(RST_PULSE_CYC));
    cyc(5);
    pll_locked = 1'b0;
    cyc(3);
    pll_locked = 1'b1;
    cycles_until(1'b1, 1'b1, 100, n);
    check("relock_after_settle_drop", 32'(n), 32'(LOCK_LAT));

    // force_relock in the same cycle that the synchronized lock falls.
    pll_locked = 1'b0;
    cyc(2);
    force_relock = 1'b1;
    @(negedge refclk);
    force_relock = 1'b0;
    check("force_loss_ready", 32'(ready), 32'd0);
    check("force_loss_pll_rst", 32'(pll_rst), 32'd1);
    pll_locked = 1'b1;
    cycles_until(1'b1, 1'b1, 100, n);
    check("relock_after_force", 32'(n) < 32'd100, 32'd1);

    // Lock never arrives: periodic retries, then timeout counter saturation.
    pll_locked = 1'b0;
    cyc(3 * (RST_PULSE_CYC + LOCK_TIMEOUT_CYC));
    cyc((SAT + 5) * (RST_PULSE_CYC + LOCK_TIMEOUT_CYC));
    check("no_lock_ready_low", 32'(ready), 32'd0);
`ifdef PLL_SUP_STATUS_EN
    check("tmo_saturated", 32'(tmo_cnt), 32'(SAT));
`endif

    // Asynchronous reset in RUN and in STABLE.
    do_reset("rst_wait");
    pll_locked = 1'b1;
    cycles_until(1'b1, 1'b1, 100, n);
    check("reach_run_before_rst", 32'(ready), 32'd1);
    do_reset("rst_run");
    cycles_until(1'b0, 1'b0, 50, n);
    cyc(SYNC_STAGES + 3);
    do_reset("rst_stable");

    // Randomized lock behaviour with occasional relock requests.
    for (int i = 0; i < 1500; i++) begin
      @(negedge refclk);
      if ($urandom_range(0, 29) == 0) pll_locked = ~pll_locked;
      force_relock = ($urandom_range(0, 149) == 0);
    end
    force_relock = 1'b0;
    cyc(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
